// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage for the pong CPU.
// Owns the PC and issues word requests over a req/ready handshake.
// Returned words land in the instruction register. A one-entry skid buffer
// absorbs a word that arrives while decode is stalled.
// Branch redirects flush the stage; a request already issued without being
// accepted is completed in DRAIN and its data dropped.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] instr_pc,
    output logic [31:0] pc_plus8
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    // The reset PC is forced onto a word boundary, like every other PC load.
    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    logic [1:0]  state_q,       state_d;
    logic [31:0] pc_q,          pc_d;
    logic [31:0] instr_q,       instr_d;
    logic [31:0] instr_pc_q,    instr_pc_d;
    logic        instr_valid_q, instr_valid_d;
    logic [31:0] skid_q,        skid_d;
    logic [31:0] skid_pc_q,     skid_pc_d;
    // Address of the request being drained; pc_q already holds the branch target.
    logic [31:0] drain_addr_q,  drain_addr_d;

    logic        consume;
    logic        accept;
    logic [31:0] pc_inc;
    logic [31:0] target_aligned;

    // Memory-side handshake is a pure decode of state so req/addr never glitch mid-wait.
    always_comb begin
        imem_req  = 1'b0;
        imem_addr = 32'h0000_0000;
        case (state_q)
            ST_FETCH: begin
                imem_req  = 1'b1;
                imem_addr = pc_q;
            end
            ST_DRAIN: begin
                imem_req  = 1'b1;
                imem_addr = drain_addr_q;
            end
            default: begin
                imem_req  = 1'b0;
                imem_addr = 32'h0000_0000;
            end
        endcase
    end

    assign consume        = instr_valid_q & ~stall;
    assign accept         = imem_req & imem_ready;
    assign pc_inc         = pc_q + 32'd4;           // wraps modulo 2^32
    assign target_aligned = branch_target & ~32'h0000_0003;

    // Next-state logic: branch has top priority, then handshake, then consume.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;
        skid_d        = skid_q;
        skid_pc_d     = skid_pc_q;
        drain_addr_d  = drain_addr_q;

        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
                if (branch_taken) begin
                    pc_d          = target_aligned;
                    instr_valid_d = 1'b0;
                end
            end

            ST_FETCH: begin
                if (branch_taken) begin
                    pc_d          = target_aligned;
                    instr_valid_d = 1'b0;
                    if (accept) begin
                        // Word for the old path is dropped; refetch at target.
                        state_d = ST_FETCH;
                    end else begin
                        // The issued request must still complete before redirecting.
                        state_d      = ST_DRAIN;
                        drain_addr_d = pc_q;
                    end
                end else if (accept) begin
                    pc_d = pc_inc;
                    if (!instr_valid_q || consume) begin
                        instr_d       = imem_rdata;
                        instr_pc_d    = pc_q;
                        instr_valid_d = 1'b1;
                    end else begin
                        // Decode is holding instr; park the word and stop fetching.
                        skid_d    = imem_rdata;
                        skid_pc_d = pc_q;
                        state_d   = ST_FULL;
                    end
                end else if (consume) begin
                    instr_valid_d = 1'b0;
                end
            end

            ST_FULL: begin
                if (branch_taken) begin
                    // Skid contents are discarded simply by leaving FULL.
                    pc_d          = target_aligned;
                    instr_valid_d = 1'b0;
                    state_d       = ST_FETCH;
                end else if (consume) begin
                    instr_d       = skid_q;
                    instr_pc_d    = skid_pc_q;
                    instr_valid_d = 1'b1;
                    state_d       = ST_FETCH;
                end
            end

            ST_DRAIN: begin
                if (branch_taken) begin
                    pc_d          = target_aligned;
                    instr_valid_d = 1'b0;
                end
                if (accept) begin
                    state_d = ST_FETCH;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any outstanding request.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            pc_q          <= RESET_PC_ALIGNED;
            instr_q       <= 32'h0000_0000;
            instr_pc_q    <= 32'h0000_0000;
            instr_valid_q <= 1'b0;
            skid_q        <= 32'h0000_0000;
            skid_pc_q     <= 32'h0000_0000;
            drain_addr_q  <= 32'h0000_0000;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            skid_q        <= skid_d;
            skid_pc_q     <= skid_pc_d;
            drain_addr_q  <= drain_addr_d;
        end
    end

    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign instr_pc    = instr_pc_q;
    assign pc_plus8    = instr_pc_q + 32'd8;    // ARM R15 read value, wraps

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed vector bench for fetch_unit.
// Memory returns a fixed function of the requested address.
module tb_fetch_unit;

    logic        clk;
    logic        reset_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] instr_pc;
    logic [31:0] pc_plus8;

    int n_chk;
    int n_fail;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rdata    (imem_rdata),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .instr         (instr),
        .instr_valid   (instr_valid),
        .instr_pc      (instr_pc),
        .pc_plus8      (pc_plus8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h0001_0001) ^ 32'hE1A0_0000;
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    typedef struct {
        logic        rdy;
        logic        stl;
        logic        br;
        logic [31:0] tgt;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_vld;
        logic [31:0] e_ipc;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rdy, input logic stl, input logic br, input logic [31:0] tgt,
                       input logic e_req, input logic [31:0] e_addr, input logic e_vld,
                       input logic [31:0] e_ipc);
        vec_t v;
        v.rdy = rdy; v.stl = stl; v.br = br; v.tgt = tgt;
        v.e_req = e_req; v.e_addr = e_addr; v.e_vld = e_vld; v.e_ipc = e_ipc;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " req"},   {31'd0, imem_req},    32'd0);
        chk({tag, " addr"},  imem_addr,            32'd0);
        chk({tag, " vld"},   {31'd0, instr_valid}, 32'd0);
        chk({tag, " instr"}, instr,                32'd0);
        chk({tag, " ipc"},   instr_pc,             32'd0);
        chk({tag, " pc8"},   pc_plus8,             32'd8);
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        reset_n = 1'b0;
        imem_ready = 1'b0;
        stall = 1'b0;
        branch_taken = 1'b0;
        branch_target = 32'd0;

        // Directed vectors; each row is one clock, expectations are after that edge.
        // Sequential fetch with ready tied high
        add(1,0,0,32'h0,        1,32'h0000_0000,0,32'h0);
        add(1,0,0,32'h0,        1,32'h0000_0004,1,32'h0000_0000);
        add(1,0,0,32'h0,        1,32'h0000_0008,1,32'h0000_0004);
        add(1,0,0,32'h0,        1,32'h0000_000C,1,32'h0000_0008);
        add(1,0,0,32'h0,        1,32'h0000_0010,1,32'h0000_000C);
        // Ready delayed three cycles per request
        add(0,0,0,32'h0,        1,32'h0000_0010,0,32'h0000_000C);
        add(0,0,0,32'h0,        1,32'h0000_0010,0,32'h0000_000C);
        add(0,0,0,32'h0,        1,32'h0000_0010,0,32'h0000_000C);
        add(1,0,0,32'h0,        1,32'h0000_0014,1,32'h0000_0010);
        add(0,0,0,32'h0,        1,32'h0000_0014,0,32'h0000_0010);
        add(0,0,0,32'h0,        1,32'h0000_0014,0,32'h0000_0010);
        add(0,0,0,32'h0,        1,32'h0000_0014,0,32'h0000_0010);
        add(1,0,0,32'h0,        1,32'h0000_0018,1,32'h0000_0014);
        // Stall for four cycles while the next word returns -> skid / FULL
        add(1,0,0,32'h0,        1,32'h0000_001C,1,32'h0000_0018);
        add(1,1,0,32'h0,        0,32'h0000_0000,1,32'h0000_0018);
        add(1,1,0,32'h0,        0,32'h0000_0000,1,32'h0000_0018);
        add(1,1,0,32'h0,        0,32'h0000_0000,1,32'h0000_0018);
        add(1,1,0,32'h0,        0,32'h0000_0000,1,32'h0000_0018);
        add(1,0,0,32'h0,        1,32'h0000_0020,1,32'h0000_001C);
        add(1,0,0,32'h0,        1,32'h0000_0024,1,32'h0000_0020);
        // Branch while waiting -> DRAIN holds old address, target aligned
        add(0,0,0,32'h0,        1,32'h0000_0024,0,32'h0000_0020);
        add(0,0,1,32'h0000_0103,1,32'h0000_0024,0,32'h0000_0020);
        add(0,0,0,32'h0,        1,32'h0000_0024,0,32'h0000_0020);
        add(1,0,0,32'h0,        1,32'h0000_0100,0,32'h0000_0020);
        add(1,0,0,32'h0,        1,32'h0000_0104,1,32'h0000_0100);
        // Branch and accept together with stall high -> flush, no skid
        add(1,1,1,32'h0000_0200,1,32'h0000_0200,0,32'h0000_0100);
        add(0,1,0,32'h0,        1,32'h0000_0200,0,32'h0000_0100);
        add(1,1,0,32'h0,        1,32'h0000_0204,1,32'h0000_0200);
        // Branch out of FULL discards the skid word
        add(1,1,0,32'h0,        0,32'h0000_0000,1,32'h0000_0200);
        add(0,1,1,32'h0000_0300,1,32'h0000_0300,0,32'h0000_0200);
        add(1,0,0,32'h0,        1,32'h0000_0304,1,32'h0000_0300);
        // PC wrap at the top of the address space
        add(1,0,1,32'hFFFF_FFFC,1,32'hFFFF_FFFC,0,32'h0000_0300);
        add(1,0,0,32'h0,        1,32'h0000_0000,1,32'hFFFF_FFFC);
        add(1,0,0,32'h0,        1,32'h0000_0004,1,32'h0000_0000);
        // Second branch while already draining: stays DRAIN, last target wins
        add(0,0,0,32'h0,        1,32'h0000_0004,0,32'h0000_0000);
        add(0,0,1,32'h0000_0040,1,32'h0000_0004,0,32'h0000_0000);
        add(0,0,1,32'h0000_0080,1,32'h0000_0004,0,32'h0000_0000);
        add(1,0,0,32'h0,        1,32'h0000_0080,0,32'h0000_0000);
        add(1,0,0,32'h0,        1,32'h0000_0084,1,32'h0000_0080);
        add(0,0,0,32'h0,        1,32'h0000_0084,0,32'h0000_0080);

        // Reset values while held in reset
        @(posedge clk);
        @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        reset_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            imem_ready    = vecs[i].rdy;
            stall         = vecs[i].stl;
            branch_taken  = vecs[i].br;
            branch_target = vecs[i].tgt;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d req", i), {31'd0, imem_req}, {31'd0, vecs[i].e_req});
            if (vecs[i].e_req)
                chk($sformatf("v%0d addr", i), imem_addr, vecs[i].e_addr);
            chk($sformatf("v%0d vld", i), {31'd0, instr_valid}, {31'd0, vecs[i].e_vld});
            if (vecs[i].e_vld) begin
                chk($sformatf("v%0d ipc", i),   instr_pc, vecs[i].e_ipc);
                chk($sformatf("v%0d instr", i), instr,    mem_word(vecs[i].e_ipc));
                chk($sformatf("v%0d pc8", i),   pc_plus8, vecs[i].e_ipc + 32'd8);
            end
        end

        // Asynchronous reset in the middle of a wait, between clock edges
        branch_taken = 1'b0;
        imem_ready   = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        chk_reset_outputs("async");
        @(posedge clk);
        #1;
        chk_reset_outputs("held");

        // Branch on the release edge out of IDLE loads the aligned target
        reset_n       = 1'b1;
        branch_taken  = 1'b1;
        branch_target = 32'h0000_1003;
        @(posedge clk);
        #1;
        chk("idle-br req",  {31'd0, imem_req},    32'd1);
        chk("idle-br addr", imem_addr,            32'h0000_1000);
        chk("idle-br vld",  {31'd0, instr_valid}, 32'd0);
        branch_taken = 1'b0;
        imem_ready   = 1'b1;
        @(posedge clk);
        #1;
        chk("idle-br ipc",   instr_pc,             32'h0000_1000);
        chk("idle-br instr", instr,                mem_word(32'h0000_1000));
        chk("idle-br vld2",  {31'd0, instr_valid}, 32'd1);
        chk("idle-br next",  imem_addr,            32'h0000_1004);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
